// File: rtl/ft_pkg.sv
// rtl/ft_pkg.sv - shared types and constants for the FT2232H sync FIFO transmit path
// Contents:
//   FT_DATA_W     : FT2232H data bus width (8 only)
//   FT_STAT_W     : width of the optional statistics counters
//   ft_tx_state_t : occupancy state of the output/skid register pair
package ft_pkg;

  localparam int FT_DATA_W = 8;
  localparam int FT_STAT_W = 32;

  // IDLE: nothing held; SEND: output register only; FULL: output and skid registers
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FULL = 2'd2
  } ft_tx_state_t;

endpackage

// File: rtl/ft_skid_buf.sv
// rtl/ft_skid_buf.sv - generic 2-entry valid/ready skid register (output register + skid)
// Ports:
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   s_data_i/s_valid_i/s_ready_o : upstream handshake, s_ready_o registered
//   m_data_o/m_valid_o/m_ready_i : downstream, m_data_o is the output register
//   m_valid_next_o  : output-register valid flag as it will be after this edge
module ft_skid_buf
  import ft_pkg::*;
#(
  parameter int W = FT_DATA_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  output logic [W-1:0] m_data_o,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic         m_valid_next_o
);

  ft_tx_state_t state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q;
  logic         acc;
  logic         take;

  assign acc  = s_valid_i && ready_q;
  assign take = m_ready_i && (state_q != IDLE);

  // The output register only changes on a take or when loaded while empty,
  // so a byte presented downstream is never altered while pending.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = SEND;
          out_d   = s_data_i;
        end
      end
      SEND: begin
        if (take && acc) begin
          out_d = s_data_i;
        end else if (take) begin
          state_d = IDLE;
        end else if (acc) begin
          state_d = FULL;
          skid_d  = s_data_i;
        end
      end
      FULL: begin
        // ready_q is low in FULL, so no new byte can arrive here
        if (take) begin
          state_d = SEND;
          out_d   = skid_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != FULL);
    end
  end

  assign s_ready_o      = ready_q;
  assign m_data_o       = out_q;
  assign m_valid_o      = (state_q != IDLE);
  assign m_valid_next_o = (state_d != IDLE);

endmodule

// File: rtl/ft_sync_tx.sv
// rtl/ft_sync_tx.sv - FT2232H 245 synchronous FIFO write controller with TXE# flow control
// Ports:
//   comm_clk, rst_n        : FT2232H CLKOUT, synchronous active-low reset
//   s_data/s_valid/s_ready : upstream byte handshake (s_ready registered)
//   txe                    : FT2232H TXE#, low when the chip has space
//   data, wr, rd           : FT2232H data bus, WR# (registered), RD# (tied high)
//   busy                   : an unsent byte is held
//   byte_count/stall_count : statistics, present only when FT_TX_STATS_EN is defined
module ft_sync_tx
  import ft_pkg::*;
#(
  parameter int DATA_W = FT_DATA_W
) (
  input  logic                 comm_clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 txe,
  output logic [DATA_W-1:0]    data,
  output logic                 wr,
  output logic                 rd,
  output logic                 busy
`ifdef FT_TX_STATS_EN
  ,
  output logic [FT_STAT_W-1:0] byte_count,
  output logic [FT_STAT_W-1:0] stall_count
`endif
);

  logic wr_q, wr_d;
  logic xfer;
  logic out_valid;
  logic out_valid_next;

  // The chip takes the byte on an edge where WR# and TXE# are both low.
  assign xfer = !wr_q && !txe;

  ft_skid_buf #(
    .W (DATA_W)
  ) u_skid (
    .clk_i          (comm_clk),
    .rst_ni         (rst_n),
    .s_data_i       (s_data),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready),
    .m_data_o       (data),
    .m_valid_o      (out_valid),
    .m_ready_i      (xfer),
    .m_valid_next_o (out_valid_next)
  );

  // WR# only goes low for a held byte while TXE# is seen low; a TXE# rise
  // releases WR# and the same byte stays on the bus for re-presentation.
  assign wr_d = !(out_valid_next && !txe);

  always_ff @(posedge comm_clk) begin
    if (!rst_n) begin
      wr_q <= 1'b1;
    end else begin
      wr_q <= wr_d;
    end
  end

  assign wr   = wr_q;
  assign rd   = 1'b1;
  assign busy = out_valid;

`ifdef FT_TX_STATS_EN
  localparam logic [FT_STAT_W-1:0] STAT_ONE = FT_STAT_W'(1);

  logic [FT_STAT_W-1:0] byte_count_q;
  logic [FT_STAT_W-1:0] stall_count_q;

  always_ff @(posedge comm_clk) begin
    if (!rst_n) begin
      byte_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      if (xfer) begin
        byte_count_q <= byte_count_q + STAT_ONE;
      end
      if (out_valid && txe) begin
        stall_count_q <= stall_count_q + STAT_ONE;
      end
    end
  end

  assign byte_count  = byte_count_q;
  assign stall_count = stall_count_q;
`else
  // No statistics state in this build.
`endif

endmodule

// File: tb/tb_ft_sync_tx.sv
// tb/tb_ft_sync_tx.sv - randomized self-checking bench for ft_sync_tx against a byte-queue reference model
module tb_ft_sync_tx;
  import ft_pkg::*;

  logic       comm_clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       txe;
  logic [7:0] data;
  logic       wr;
  logic       rd;
  logic       busy;
`ifdef FT_TX_STATS_EN
  logic [31:0] byte_count;
  logic [31:0] stall_count;
`endif

  always #5 comm_clk = ~comm_clk;

  ft_sync_tx dut (
    .comm_clk    (comm_clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .txe         (txe),
    .data        (data),
    .wr          (wr),
    .rd          (rd),
    .busy        (busy)
`ifdef FT_TX_STATS_EN
    ,
    .byte_count  (byte_count),
    .stall_count (stall_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the block is a FIFO of at most two pending bytes whose
  // front byte sits on the pins.
  logic [7:0]  m_q[$];
  logic        m_wr     = 1'b1;
  logic        m_rdy    = 1'b0;
  logic [7:0]  m_data   = 8'h00;
  logic [31:0] m_bytes  = 0;
  logic [31:0] m_stalls = 0;
  bit          m_acc;

  logic [7:0]  pin_q[$];   // bytes actually taken at the pins
  logic [7:0]  sent_q[$];  // bytes accepted from upstream, in order

  task automatic step();
    bit xfer;
    // Pin-level observation of the edge about to occur.
    if (wr === 1'b0 && txe == 1'b0) pin_q.push_back(data);
    @(posedge comm_clk);
    xfer  = (m_wr == 1'b0) && !txe;
    m_acc = 1'b0;
    if (!rst_n) begin
      m_q.delete();
      m_wr     = 1'b1;
      m_rdy    = 1'b0;
      m_data   = 8'h00;
      m_bytes  = 0;
      m_stalls = 0;
    end else begin
      m_acc = s_valid && m_rdy;
      if (m_q.size() > 0 && txe) m_stalls++;
      if (xfer) begin
        void'(m_q.pop_front());
        m_bytes++;
      end
      if (m_acc) begin
        m_q.push_back(s_data);
        sent_q.push_back(s_data);
      end
      if (m_q.size() > 0) m_data = m_q[0];
      m_rdy = (m_q.size() < 2);
      m_wr  = !(m_q.size() > 0 && !txe);
    end
    @(negedge comm_clk);
    check("wr", 32'(wr), 32'(m_wr));
    check("rd", 32'(rd), 32'd1);
    check("data", 32'(data), 32'(m_data));
    check("s_ready", 32'(s_ready), 32'(m_rdy));
    check("busy", 32'(busy), 32'(m_q.size() > 0));
`ifdef FT_TX_STATS_EN
    check("byte_count", byte_count, m_bytes);
    check("stall_count", stall_count, m_stalls);
`endif
  endtask

  task automatic drain(input int n);
    s_valid = 1'b0;
    txe     = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic compare_stream(input string tag);
    int bad = 0;
    check({tag, "_len"}, 32'(pin_q.size()), 32'(sent_q.size()));
    for (int i = 0; i < pin_q.size() && i < sent_q.size(); i++)
      if (pin_q[i] !== sent_q[i]) bad++;
    check({tag, "_order"}, 32'(bad), 32'd0);
  endtask

  // Stream 0x00..0xFF; optionally pull TXE# high for 2 cycles while blip_at is on the pins.
  task automatic stream(input int blip_at, output int max_run);
    int  nxt = 0;
    int  guard = 0;
    int  blip_left = 0;
    bit  blip_done = 0;
    int  run = 0;
    int  bad = 0;
    max_run = 0;
    pin_q.delete();
    sent_q.delete();
    while (pin_q.size() < 256 && guard < 2000) begin
      s_valid = (nxt < 256);
      s_data  = nxt[7:0];
      txe     = 1'b0;
      if (blip_left > 0) begin
        txe = 1'b1;
        blip_left--;
      end else if (!blip_done && blip_at >= 0 && m_q.size() > 0 &&
                   32'(m_q[0]) == 32'(blip_at) && m_wr == 1'b0) begin
        txe       = 1'b1;
        blip_left = 1;
        blip_done = 1;
      end
      step();
      if (m_acc) nxt++;
      if (wr === 1'b0) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      guard++;
    end
    check("stream_timeout", 32'(guard < 2000), 32'd1);
    check("stream_count", 32'(pin_q.size()), 32'd256);
    for (int i = 0; i < pin_q.size(); i++)
      if (32'(pin_q[i]) != 32'(i)) bad++;
    check("stream_sequence", 32'(bad), 32'd0);
  endtask

  initial begin
    int max_run;
    int accepts;
    int consec;
    int wr_low;
    logic [31:0] bytes_before;

    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    txe     = 1'b0;

    // Reset held with upstream valid: outputs stay in reset values.
    for (int i = 0; i < 5; i++) begin
      s_data = 8'($urandom);
      step();
      check("reset_wr", 32'(wr), 32'd1);
      check("reset_s_ready", 32'(s_ready), 32'd0);
      check("reset_data", 32'(data), 32'd0);
    end
    rst_n   = 1'b1;
    s_valid = 1'b0;
    step();
    check("ready_after_release", 32'(s_ready), 32'd1);
    drain(2);

    // Full-rate stream: one unbroken WR# low window of 256 cycles.
    stream(-1, max_run);
    check("stream_wr_run", 32'(max_run), 32'd256);
    drain(4);

    // Same stream with a TXE# blip at byte 0x40.
    stream(8'h40, max_run);
    drain(4);

    // Long backpressure from idle.
    pin_q.delete();
    sent_q.delete();
    bytes_before = m_bytes;
    accepts = 0;
    s_valid = 1'b1;
    txe     = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_data = 8'($urandom);
      step();
      if (m_acc) accepts++;
    end
    check("backpressure_accepts", 32'(accepts), 32'd2);
    check("backpressure_ready", 32'(s_ready), 32'd0);
`ifdef FT_TX_STATS_EN
    check("backpressure_bytes", byte_count, bytes_before);
`endif
    drain(6);
    compare_stream("backpressure");

    // Sparse upstream: one byte every third cycle, each shown for one cycle.
    pin_q.delete();
    sent_q.delete();
    consec = 0;
    wr_low = 0;
    for (int i = 0; i < 90; i++) begin
      s_valid = (i % 3 == 0);
      s_data  = 8'($urandom);
      txe     = 1'b0;
      step();
      if (wr === 1'b0) begin
        wr_low++;
        if (i > 0 && wr_low > 1 && consec == 1) consec = 2;
        else if (consec != 2) consec = 1;
      end else if (consec != 2) begin
        consec = 0;
      end
    end
    drain(4);
    check("sparse_wr_low_cycles", 32'(wr_low), 32'd30);
    check("sparse_no_back_to_back", 32'(consec == 2), 32'd0);
    compare_stream("sparse");

    // Randomized traffic with bursty TXE#.
    pin_q.delete();
    sent_q.delete();
    for (int i = 0; i < 3000; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) txe = ~txe;
      step();
    end
    drain(6);
    compare_stream("random");

    // Reset while FULL: pending bytes are dropped and never reach the pins.
    s_valid = 1'b1;
    txe     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 8'($urandom);
      step();
    end
    check("midreset_full_busy", 32'(busy), 32'd1);
    check("midreset_full_ready", 32'(s_ready), 32'd0);
    pin_q.delete();
    rst_n = 1'b0;
    step();
    check("midreset_wr", 32'(wr), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
`ifdef FT_TX_STATS_EN
    check("midreset_bytes", byte_count, 32'd0);
    check("midreset_stalls", stall_count, 32'd0);
`endif
    rst_n = 1'b1;
    drain(10);
    check("midreset_no_xfer", 32'(pin_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
